// File: rtl/i2s_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : i2s_master_ctrl
// Purpose  : I2S master clock generator with sample-pair capture and overrun flag.
//            Optional macro I2S_CTRL_OVERRUN_CNT_EN adds a 16-bit overrun counter.
// Revision : 1.0
// ============================================================================
module i2s_master_ctrl #(
    parameter int WIDTH   = 32,
    parameter int DIV     = 4,
    parameter int CAP_BIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             sclk,
    output logic             lrck,
    input  logic [WIDTH-1:0] rx_ldata,
    input  logic [WIDTH-1:0] rx_rdata,
    output logic [WIDTH-1:0] out_ldata,
    output logic [WIDTH-1:0] out_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    input  logic             overrun_clr,
`ifdef I2S_CTRL_OVERRUN_CNT_EN
    output logic [15:0]      overrun_cnt,
`endif
    output logic             busy
);

    localparam int BW = $clog2(2 * WIDTH);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [DW-1:0]   div_cnt;
    logic [BW-1:0]   bit_cnt;
    logic [BW-1:0]   bit_nxt;
    logic            div_wrap;
    logic            fall;
    logic            frame_wrap;
    logic            cap_pt;
    logic            take;
    logic            hold;
    logic            armed;

    assign div_wrap   = (state != S_IDLE) && (div_cnt == DW'(DIV - 1));
    assign fall       = div_wrap && sclk;
    assign frame_wrap = (bit_cnt == BW'(2 * WIDTH - 1));
    assign bit_nxt    = frame_wrap ? '0 : bit_cnt + BW'(1);
    assign cap_pt     = fall && (bit_nxt == BW'(CAP_BIT));
    // armed stays low until the first capture point after IDLE, discarding stale rx data
    assign take       = cap_pt && armed;
    assign hold       = out_valid && !out_ready;
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (en) next_state = S_RUN;
            S_RUN:   if (!en) next_state = S_DRAIN;
            S_DRAIN: begin
                if (en) begin
                    next_state = S_RUN;
                end else if (fall && frame_wrap) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
            lrck    <= 1'b0;
            armed   <= 1'b0;
        end else if (state == S_IDLE) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
            lrck    <= 1'b0;
            armed   <= 1'b0;
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + DW'(1);
            if (div_wrap) begin
                sclk <= ~sclk;
            end
            if (fall) begin
                bit_cnt <= bit_nxt;
                lrck    <= (bit_nxt >= BW'(WIDTH));
            end
            if (cap_pt) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ldata <= '0;
            out_rdata <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (take && !hold) begin
                out_ldata <= rx_ldata;
                out_rdata <= rx_rdata;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (take && hold) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef I2S_CTRL_OVERRUN_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_cnt <= '0;
        end else if (take && hold) begin
            if (overrun_clr) begin
                overrun_cnt <= 16'd1;
            end else if (overrun_cnt != 16'hFFFF) begin
                overrun_cnt <= overrun_cnt + 16'd1;
            end
        end else if (overrun_clr) begin
            overrun_cnt <= '0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2s_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_master_ctrl
// Purpose  : Directed self-checking bench for i2s_master_ctrl (WIDTH=32, DIV=2).
// Revision : 1.0
// ============================================================================
module tb_i2s_master_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        sclk;
    logic        lrck;
    logic [31:0] rx_ldata;
    logic [31:0] rx_rdata;
    logic [31:0] out_ldata;
    logic [31:0] out_rdata;
    logic        out_valid;
    logic        out_ready;
    logic        overrun;
    logic        overrun_clr;
    logic        busy;
`ifdef I2S_CTRL_OVERRUN_CNT_EN
    logic [15:0] overrun_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int t      = 0;

    i2s_master_ctrl #(.WIDTH(32), .DIV(2), .CAP_BIT(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .sclk        (sclk),
        .lrck        (lrck),
        .rx_ldata    (rx_ldata),
        .rx_rdata    (rx_rdata),
        .out_ldata   (out_ldata),
        .out_rdata   (out_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
`ifdef I2S_CTRL_OVERRUN_CNT_EN
        .overrun_cnt (overrun_cnt),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic go_to(input int target);
        while (t < target) step();
    endtask

    // t=0 is the first cycle in RUN after leaving IDLE
    task automatic start_run(input logic rdy, input logic [31:0] l, input logic [31:0] r);
        rst_n = 1'b0;
        en = 1'b0;
        overrun_clr = 1'b0;
        out_ready = rdy;
        rx_ldata = l;
        rx_rdata = r;
        step();
        step();
        rst_n = 1'b1;
        en = 1'b1;
        step();
        t = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b0;
        out_ready = 1'b0;
        overrun_clr = 1'b0;
        rx_ldata = 32'h0;
        rx_rdata = 32'h0;
        step();
        step();
        checks++;
        if ({sclk, lrck, out_valid, overrun, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 00000", {sclk, lrck, out_valid, overrun, busy});
        end
        checks++;
        if ({out_ldata, out_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0", {out_ldata, out_rdata});
        end
        rst_n = 1'b1;
        repeat (6) step();
        checks++;
        if ({busy, sclk} !== 2'b00) begin
            errors++;
            $display("FAIL idle_wait_en got busy,sclk=%b exp 00", {busy, sclk});
        end
    endtask

    task automatic test_timing();
        logic exp_sclk, exp_lrck, exp_valid;
        start_run(1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL run_busy got %b exp 1", busy);
        end
        while (t <= 560) begin
            exp_sclk  = ((t / 2) % 2) == 1;
            exp_lrck  = ((t / 4) % 64) >= 32;
            exp_valid = (t >= 288) && (((t - 288) % 256) == 0);
            checks++;
            if (sclk !== exp_sclk) begin
                errors++;
                $display("FAIL sclk t=%0d got %b exp %b", t, sclk, exp_sclk);
            end
            checks++;
            if (lrck !== exp_lrck) begin
                errors++;
                $display("FAIL lrck t=%0d got %b exp %b", t, lrck, exp_lrck);
            end
            checks++;
            if (out_valid !== exp_valid) begin
                errors++;
                $display("FAIL valid t=%0d got %b exp %b", t, out_valid, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if ({out_ldata, out_rdata, overrun} !== {32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0}) begin
                    errors++;
                    $display("FAIL cap_data t=%0d got %h %h ovr=%b exp a5a5a5a5 5a5a5a5a ovr=0",
                             t, out_ldata, out_rdata, overrun);
                end
            end
            step();
        end
    endtask

    task automatic test_overrun();
        start_run(1'b0, 32'h11111111, 32'h22222222);
        go_to(288);
        checks++;
        if ({out_valid, out_ldata, out_rdata} !== {1'b1, 32'h11111111, 32'h22222222}) begin
            errors++;
            $display("FAIL ovr_first got v=%b %h %h exp v=1 11111111 22222222", out_valid, out_ldata, out_rdata);
        end
        go_to(300);
        rx_ldata = 32'h33333333;
        rx_rdata = 32'h44444444;
        go_to(543);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_before got %b exp 0", overrun);
        end
        step();
        checks++;
        if ({out_valid, out_ldata, out_rdata, overrun} !== {1'b1, 32'h11111111, 32'h22222222, 1'b1}) begin
            errors++;
            $display("FAIL ovr_drop got v=%b %h %h ovr=%b exp v=1 11111111 22222222 ovr=1",
                     out_valid, out_ldata, out_rdata, overrun);
        end
`ifdef I2S_CTRL_OVERRUN_CNT_EN
        checks++;
        if (overrun_cnt !== 16'd1) begin
            errors++;
            $display("FAIL ovr_cnt got %0d exp 1", overrun_cnt);
        end
`endif
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        checks++;
        if ({overrun, out_valid} !== 2'b01) begin
            errors++;
            $display("FAIL ovr_clr got ovr,v=%b exp 01", {overrun, out_valid});
        end
`ifdef I2S_CTRL_OVERRUN_CNT_EN
        checks++;
        if (overrun_cnt !== 16'd0) begin
            errors++;
            $display("FAIL ovr_cnt_clr got %0d exp 0", overrun_cnt);
        end
`endif
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL accept_clears got %b exp 0", out_valid);
        end
    endtask

    task automatic test_collision();
        start_run(1'b0, 32'h11111111, 32'h22222222);
        go_to(288);
        rx_ldata = 32'h55555555;
        rx_rdata = 32'h66666666;
        go_to(543);
        out_ready = 1'b1;
        step();
        checks++;
        if ({out_valid, out_ldata, out_rdata, overrun} !== {1'b1, 32'h55555555, 32'h66666666, 1'b0}) begin
            errors++;
            $display("FAIL collide got v=%b %h %h ovr=%b exp v=1 55555555 66666666 ovr=0",
                     out_valid, out_ldata, out_rdata, overrun);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL collide_after got %b exp 0", out_valid);
        end
        out_ready = 1'b0;
        rx_ldata = 32'h77777777;
        rx_rdata = 32'h88888888;
        go_to(800);
        checks++;
        if ({out_valid, out_ldata} !== {1'b1, 32'h77777777}) begin
            errors++;
            $display("FAIL third_cap got v=%b %h exp v=1 77777777", out_valid, out_ldata);
        end
        go_to(1055);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        checks++;
        if ({overrun, out_ldata} !== {1'b1, 32'h77777777}) begin
            errors++;
            $display("FAIL set_wins got ovr=%b %h exp ovr=1 77777777", overrun, out_ldata);
        end
`ifdef I2S_CTRL_OVERRUN_CNT_EN
        checks++;
        if (overrun_cnt !== 16'd1) begin
            errors++;
            $display("FAIL cnt_set_wins got %0d exp 1", overrun_cnt);
        end
`endif
    endtask

    task automatic test_drain();
        logic exp_sclk;
        start_run(1'b1, 32'h0, 32'h0);
        go_to(41);
        en = 1'b0;
        go_to(102);
        checks++;
        if ({busy, sclk} !== 2'b11) begin
            errors++;
            $display("FAIL drain_mid got busy,sclk=%b exp 11", {busy, sclk});
        end
        go_to(255);
        checks++;
        if ({busy, sclk, lrck} !== 3'b111) begin
            errors++;
            $display("FAIL drain_last got %b exp 111", {busy, sclk, lrck});
        end
        step();
        checks++;
        if ({busy, sclk, lrck} !== 3'b000) begin
            errors++;
            $display("FAIL drain_idle got %b exp 000", {busy, sclk, lrck});
        end
        go_to(262);
        checks++;
        if ({busy, sclk} !== 2'b00) begin
            errors++;
            $display("FAIL idle_quiet got %b exp 00", {busy, sclk});
        end

        start_run(1'b1, 32'h12345678, 32'h9ABCDEF0);
        go_to(41);
        en = 1'b0;
        go_to(161);
        en = 1'b1;
        while (t <= 300) begin
            exp_sclk = ((t / 2) % 2) == 1;
            checks++;
            if ({busy, sclk} !== {1'b1, exp_sclk}) begin
                errors++;
                $display("FAIL resume t=%0d got busy,sclk=%b exp 1%b", t, {busy, sclk}, exp_sclk);
            end
            if (t == 288) begin
                checks++;
                if ({out_valid, out_ldata} !== {1'b1, 32'h12345678}) begin
                    errors++;
                    $display("FAIL resume_cap got v=%b %h exp v=1 12345678", out_valid, out_ldata);
                end
            end
            step();
        end
    endtask

    task automatic test_reset_midframe();
        start_run(1'b0, 32'hCAFEF00D, 32'hDEADBEEF);
        go_to(288);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_valid got %b exp 1", out_valid);
        end
        go_to(457);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sclk, lrck, out_valid, overrun, busy, out_ldata, out_rdata} !== 69'h0) begin
            errors++;
            $display("FAIL async_reset got %b %h %h exp all 0",
                     {sclk, lrck, out_valid, overrun, busy}, out_ldata, out_rdata);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        t = 0;
        go_to(34);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL suppress_again got %b exp 0", out_valid);
        end
        go_to(288);
        checks++;
        if ({out_valid, out_ldata, out_rdata} !== {1'b1, 32'hCAFEF00D, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL post_reset_cap got v=%b %h %h exp v=1 cafef00d deadbeef",
                     out_valid, out_ldata, out_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_overrun();
        test_collision();
        test_drain();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2s_master_ctrl.md
I2S_MASTER_CTRL -- requirements
Module: i2s_master_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, bits per channel slot; frame = 2*WIDTH SCLK periods.
REQ-002 Parameter DIV, default 4, clk cycles per SCLK half-period; legal range 1..255.
REQ-003 Parameter CAP_BIT, default 8, SCLK count within the left slot at which a sample pair is captured; legal range 4..WIDTH-1.
REQ-004 clk  in  1  system clock; every register in the block is clocked on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 en  in  1  run request; level-sensitive.
REQ-007 sclk  out  1  I2S bit clock driven to the i2s_rx instance and the codec.
REQ-008 lrck  out  1  I2S word select; 0 = left slot, 1 = right slot.
REQ-009 rx_ldata  in  WIDTH  left-channel word from i2s_rx.
REQ-010 rx_rdata  in  WIDTH  right-channel word from i2s_rx.
REQ-011 out_ldata  out  WIDTH  captured left word.
REQ-012 out_rdata  out  WIDTH  captured right word.
REQ-013 out_valid  out  1  captured pair available.
REQ-014 out_ready  in  1  consumer accepts the pair.
REQ-015 overrun  out  1  sticky flag: a capture found out_valid=1 and out_ready=0.
REQ-016 overrun_clr  in  1  clears overrun.
REQ-017 busy  out  1  state is not IDLE.

Function
REQ-018 FSM states and transitions:
- IDLE -> RUN when en=1.
- RUN -> DRAIN when en=0.
- DRAIN -> RUN when en=1.
- DRAIN -> IDLE at frame end, i.e. when bit_cnt wraps from 2*WIDTH-1 to 0.
REQ-019 IDLE behaviour: sclk=0, lrck=0, div_cnt=0, bit_cnt=0; no captures occur.
REQ-020 Divider: in RUN/DRAIN, div_cnt counts 0..DIV-1; at DIV-1 it wraps to 0 and sclk toggles, giving an SCLK period of 2*DIV clk cycles.
REQ-021 Falling edges of sclk: bit_cnt (0..2*WIDTH-1, wrapping) increments on each falling edge, and lrck = (bit_cnt >= WIDTH); lrck therefore changes only on falling edges of sclk.
REQ-022 First rising edge of sclk occurs DIV clk cycles after entering RUN from IDLE.
REQ-023 Capture point: the cycle in which sclk falls and bit_cnt becomes CAP_BIT.
REQ-024 At a capture point, rx_ldata and rx_rdata are sampled together into the out_* registers, except as stated in REQ-025 and REQ-027.
REQ-025 The first capture point after leaving IDLE is suppressed because rx data is stale; captures begin with the second frame.
REQ-026 out_valid is set on an accepted capture; out_ldata and out_rdata stay stable while out_valid=1 and out_ready=0.
REQ-027 If a capture point occurs while out_valid=1 and out_ready=0, the new pair is dropped, the held pair is kept, and overrun is set.
REQ-028 If a capture point coincides with out_valid=1 and out_ready=1, the new pair is loaded and out_valid stays 1; this is not an overrun.
REQ-029 out_valid=1 and out_ready=1 with no capture point clears out_valid on the next clk.
REQ-030 overrun_clr clears overrun; if overrun_clr coincides with a new overrun, the set wins.
REQ-031 Captures continue during DRAIN; a pending out_valid survives the return to IDLE until it is accepted.

Reset
REQ-032 While rst_n=0, the block holds:
- state=IDLE, sclk=0, lrck=0, counters=0;
- out_valid=0, out_ldata=0, out_rdata=0;
- overrun=0, busy=0.
REQ-033 Assertion of rst_n mid-frame immediately applies REQ-032, and the pending pair is lost.
REQ-034 After reset release, the block stays in IDLE until en=1 is sampled.

Configuration
REQ-035 With macro I2S_CTRL_OVERRUN_CNT_EN defined, port overrun_cnt (out, 16 bits) is added. It increments once per dropped pair, saturates at 0xFFFF, is cleared by overrun_clr (an increment in the same cycle wins, giving 1), and resets to 0.
REQ-036 Without I2S_CTRL_OVERRUN_CNT_EN, the overrun_cnt port and its logic are absent; all other behaviour is unchanged.

Verification
REQ-037 Timing, WIDTH=32, DIV=2, en=1 from reset release, out_ready=1:
- sclk period 4 clk;
- lrck period 256 clk;
- first out_valid pulse at second frame bit 8, one every 256 clk thereafter.
REQ-038 Capture data: rx_ldata=0xA5A5A5A5, rx_rdata=0x5A5A5A5A held constant -> each out pair equals these values and overrun stays 0.
REQ-039 Overrun: out_ready=0 across two capture points -> first pair held, overrun=1 after the second capture, overrun_cnt=1 when I2S_CTRL_OVERRUN_CNT_EN is defined; overrun_clr pulse -> overrun=0.
REQ-040 Drain: en=0 at bit_cnt=10 -> busy=1 until frame end, then IDLE with sclk=0 and lrck=0; en=1 again at bit_cnt=40 of DRAIN -> no gap in sclk.
REQ-041 Reset mid-frame: rst_n=0 at bit_cnt=50 with out_valid=1 -> all outputs 0 in the same cycle; after release with en=1 the first capture is suppressed again.
REQ-042 Accept/capture collision: out_ready=1 on the exact capture-point cycle with out_valid=1 -> new pair loaded, out_valid remains 1, overrun=0.
